// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, op/state encodings and result constants for ex_muldiv
package muldiv_pkg;
    localparam int XLEN = 32;
    localparam int ITER = XLEN;
    localparam int CW   = $clog2(ITER) + 1;
    typedef enum logic [1:0] {MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11} md_op_e;
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_FIX = 2'b10} state_e;
    localparam logic [XLEN-1:0] DIV0_LO = '1;
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: operand magnitude/sign extraction at issue and result sign correction at fix
//   issue_signed/issue_a/issue_b -> neg_a/neg_b (operand signs), abs_a/abs_b (magnitudes)
//   run_div/run_neg_a/run_neg_b/run_zero + raw_hi/raw_lo (unsigned result) -> fix_hi/fix_lo
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic            issue_signed,
    input  logic [XLEN-1:0] issue_a,
    input  logic [XLEN-1:0] issue_b,
    output logic            neg_a,
    output logic            neg_b,
    output logic [XLEN-1:0] abs_a,
    output logic [XLEN-1:0] abs_b,
    input  logic            run_div,
    input  logic            run_neg_a,
    input  logic            run_neg_b,
    input  logic            run_zero,
    input  logic [XLEN-1:0] raw_hi,
    input  logic [XLEN-1:0] raw_lo,
    output logic [XLEN-1:0] fix_hi,
    output logic [XLEN-1:0] fix_lo
);
    logic [2*XLEN-1:0] prod;
    logic              diff_sign;
    always_comb begin
        neg_a     = issue_signed & issue_a[XLEN-1];
        neg_b     = issue_signed & issue_b[XLEN-1];
        abs_a     = neg_a ? -issue_a : issue_a;
        abs_b     = neg_b ? -issue_b : issue_b;
        diff_sign = run_neg_a ^ run_neg_b;
        prod      = diff_sign ? -{raw_hi, raw_lo} : {raw_hi, raw_lo};
        // remainder follows the dividend, so a zero divisor returns the original rs in hi
        fix_hi    = run_div ? (run_neg_a ? -raw_hi : raw_hi) : prod[2*XLEN-1:XLEN];
        fix_lo    = run_div ? (run_zero ? DIV0_LO : (diff_sign ? -raw_lo : raw_lo)) : prod[XLEN-1:0];
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative one-bit-per-cycle MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO
//   EX_start/EX_op/EX_rd1/EX_rd2 issue an op; EX_rdhilo marks MFHI/MFLO; EX_flush kills it
//   busy: op in progress; stall: busy & (EX_start | EX_rdhilo); done: one-cycle write pulse
//   hi/lo: architectural registers
//   MULDIV_EARLY_OUT_EN: finish a multiply early once the remaining multiplier bits are zero
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            EX_start,
    input  logic [1:0]      EX_op,
    input  logic [XLEN-1:0] EX_rd1,
    input  logic [XLEN-1:0] EX_rd2,
    input  logic            EX_rdhilo,
    input  logic            EX_flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    state_e          state;
    logic [CW-1:0]   cnt;
    logic            div_q, na, nb;
    logic [XLEN-1:0] m, acc, sh;
    logic            issue_signed, issue_div, neg_a, neg_b, ge;
    logic [XLEN-1:0] abs_a, abs_b, fix_hi, fix_lo;
    logic [XLEN:0]   sum, rem_s, diff;

    assign issue_signed = (EX_op == MD_MULT) || (EX_op == MD_DIV);
    assign issue_div    = (EX_op == MD_DIV) || (EX_op == MD_DIVU);
    assign stall        = busy & (EX_start | EX_rdhilo);

    // multiply: {acc,sh} is the partial product with the multiplier shifting out of sh
    // divide:   acc is the partial remainder, sh shifts dividend out and quotient in
    assign sum   = {1'b0, acc} + {1'b0, sh[0] ? m : '0};
    assign rem_s = {acc, sh[XLEN-1]};
    assign diff  = rem_s - {1'b0, m};
    assign ge    = ~diff[XLEN];

`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0]     shamt;
    logic [2*XLEN-1:0] eo;
    logic              early;
    assign shamt = CW'(ITER) - cnt;
    assign eo    = {acc, sh} >> shamt;
    assign early = ~div_q && ((sh & ({XLEN{1'b1}} >> cnt)) == '0);
`endif

    muldiv_signfix u_signfix (
        .issue_signed(issue_signed),
        .issue_a     (EX_rd1),
        .issue_b     (EX_rd2),
        .neg_a       (neg_a),
        .neg_b       (neg_b),
        .abs_a       (abs_a),
        .abs_b       (abs_b),
        .run_div     (div_q),
        .run_neg_a   (na),
        .run_neg_b   (nb),
        .run_zero    (m == '0),
        .raw_hi      (acc),
        .raw_lo      (sh),
        .fix_hi      (fix_hi),
        .fix_lo      (fix_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            div_q <= 1'b0;
            na    <= 1'b0;
            nb    <= 1'b0;
            m     <= '0;
            acc   <= '0;
            sh    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (EX_start && !EX_flush) begin
                    div_q <= issue_div;
                    na    <= neg_a;
                    nb    <= neg_b;
                    m     <= issue_div ? abs_b : abs_a;
                    sh    <= issue_div ? abs_a : abs_b;
                    acc   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= S_RUN;
                end
                S_RUN: if (EX_flush) begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end else
`ifdef MULDIV_EARLY_OUT_EN
                if (early) begin
                    acc   <= eo[2*XLEN-1:XLEN];
                    sh    <= eo[XLEN-1:0];
                    state <= S_FIX;
                end else
`endif
                begin
                    acc   <= div_q ? (ge ? diff[XLEN-1:0] : rem_s[XLEN-1:0]) : sum[XLEN:1];
                    sh    <= div_q ? {sh[XLEN-2:0], ge} : {sum[0], sh[XLEN-1:1]};
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(ITER - 1)) ? S_FIX : S_RUN;
                end
                S_FIX: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (!EX_flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic        EX_start, EX_rdhilo, EX_flush;
    logic [1:0]  EX_op;
    logic [31:0] EX_rd1, EX_rd2;
    logic        busy, stall, done;
    logic [31:0] hi, lo;
    int          n_chk = 0;
    int          n_err = 0;

    ex_muldiv dut (
        .clk      (clk),
        .rst      (rst),
        .EX_start (EX_start),
        .EX_op    (EX_op),
        .EX_rd1   (EX_rd1),
        .EX_rd2   (EX_rd2),
        .EX_rdhilo(EX_rdhilo),
        .EX_flush (EX_flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {hi,lo} as the ISA defines them
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            2'b01: return {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    // called ~1 time unit after a rising edge with the unit idle
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int          lat;
        exp      = model(op, a, b);
        EX_op    = op;
        EX_rd1   = a;
        EX_rd2   = b;
        EX_start = 1'b1;
        @(posedge clk);
        #1 EX_start = 1'b0;
        lat = 1;
        chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
        while (!done && lat < 60) begin
            @(posedge clk);
            #1 lat++;
        end
        chk({tag, " hilo"}, {hi, lo}, exp);
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) chk({tag, " latency_bound"}, 64'(lat <= 34), 64'd1);
        else        chk({tag, " latency"}, 64'(lat), 64'd34);
`else
        chk({tag, " latency"}, 64'(lat), 64'd34);
`endif
        chk({tag, " busy_after_done"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1 chk({tag, " done_pulse_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] saved, exp_a, exp_b;
        int          e, n;
        logic        seen;
        rst       = 1'b1;
        EX_start  = 1'b0;
        EX_rdhilo = 1'b0;
        EX_flush  = 1'b0;
        EX_op     = 2'b00;
        EX_rd1    = '0;
        EX_rd2    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset hilo", {hi, lo}, 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);

        do_op(2'b00, 32'd7, 32'hFFFFFFFD, "mult_7_m3");
        chk("mult_7_m3 exact", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        do_op(2'b11, 32'd100, 32'd7, "divu_100_7");
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, "div_m7_2");
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        do_op(2'b11, 32'h1234, 32'd0, "divu_by_0");
        chk("divu_by_0 exact", {hi, lo}, 64'h00001234_FFFFFFFF);
        do_op(2'b10, 32'hFFFFFF00, 32'd0, "div_neg_by_0");
        do_op(2'b01, 32'h10000, 32'd5, "multu_early");

        EX_rdhilo = 1'b1;
        #1 chk("rdhilo idle stall", 64'(stall), 64'd0);
        EX_rdhilo = 1'b0;

        // second issue held while busy, plus MFHI/MFLO read while busy
        exp_a    = model(2'b11, 32'd100, 32'd7);
        exp_b    = model(2'b10, 32'hFFFFFFF9, 32'd2);
        EX_op    = 2'b11;
        EX_rd1   = 32'd100;
        EX_rd2   = 32'd7;
        EX_start = 1'b1;
        @(posedge clk);
        #1 EX_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        EX_op    = 2'b10;
        EX_rd1   = 32'hFFFFFFF9;
        EX_rd2   = 32'd2;
        EX_start = 1'b1;
        #1 chk("held start stall", 64'(stall), 64'd1);
        repeat (5) @(posedge clk);
        #1 EX_rdhilo = 1'b1;
        #1 chk("rdhilo busy stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1 EX_rdhilo = 1'b0;
        e = 10;
        while (!done && e < 60) begin
            @(posedge clk);
            #1 e++;
        end
        chk("held first latency", 64'(e), 64'd34);
        chk("held first hilo", {hi, lo}, exp_a);
        chk("held stall released", 64'(stall), 64'd0);
        @(posedge clk);
        #1 EX_start = 1'b0;
        chk("held second accepted", 64'(busy), 64'd1);
        chk("held done dropped", 64'(done), 64'd0);
        n = 1;
        while (!done && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        chk("held second latency", 64'(n), 64'd34);
        chk("held second hilo", {hi, lo}, exp_b);
        @(posedge clk);
        #1;

        // flush mid-run
        saved    = {hi, lo};
        EX_op    = 2'b01;
        EX_rd1   = 32'hDEADBEEF;
        EX_rd2   = 32'h12345678;
        EX_start = 1'b1;
        @(posedge clk);
        #1 EX_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 EX_flush = 1'b1;
        @(posedge clk);
        #1 EX_flush = 1'b0;
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush hilo hold", {hi, lo}, saved);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1 seen |= done;
        end
        chk("flush no done", 64'(seen), 64'd0);
        chk("flush hilo later", {hi, lo}, saved);

        // flush beats a simultaneous start in idle
        EX_start = 1'b1;
        EX_flush = 1'b1;
        @(posedge clk);
        #1;
        EX_start = 1'b0;
        EX_flush = 1'b0;
        chk("flush blocks accept", 64'(busy), 64'd0);

        // async reset mid-run
        EX_op    = 2'b00;
        EX_rd1   = 32'd9;
        EX_rd2   = 32'd9;
        EX_start = 1'b1;
        @(posedge clk);
        #1 EX_start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun reset hilo", {hi, lo}, 64'd0);
        chk("midrun reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            do_op(op, a, b, $sformatf("rand%0d_op%0d_%h_%h", i, op, a, b));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
